// File: rtl/mix_columns_seq.sv
// mix_columns_seq: AES MixColumns engine that mixes COLS_PER_CYCLE columns per clock behind valid/ready handshakes.
// Optional macro MIXCOL_INV_EN adds an inv port that selects the InvMixColumns matrix for each operation.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A step of 4 truncates to 0, so the single CALC cycle starts and ends on column 0.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv_sel);
    logic [7:0] a  [4];
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x1[i] = xtime(a[i]);
      x2[i] = xtime(x1[i]);
      x3[i] = xtime(x2[i]);
      m2[i] = x1[i];
      m3[i] = x1[i] ^ a[i];
      m9[i] = x3[i] ^ a[i];
      mb[i] = x3[i] ^ x1[i] ^ a[i];
      md[i] = x3[i] ^ x2[i] ^ a[i];
      me[i] = x3[i] ^ x2[i] ^ x1[i];
    end
    if (inv_sel) begin
      res = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
             m9[0] ^ me[1] ^ mb[2] ^ md[3],
             md[0] ^ m9[1] ^ me[2] ^ mb[3],
             mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end else begin
      res = {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
             a[0]  ^ m2[1] ^ m3[2] ^ a[3],
             a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
             m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    end
    return res;
  endfunction

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_state_q, out_state_d;
  logic [127:0] mixed_s;
  logic         inv_sel_s;

`ifdef MIXCOL_INV_EN
  logic inv_q, inv_d;
  assign inv_sel_s = inv_q;
`else
  assign inv_sel_s = 1'b0;
`endif

  // State register: all flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      work_q      <= 128'd0;
      out_state_q <= 128'd0;
`ifdef MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_state_q <= out_state_d;
`ifdef MIXCOL_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  // Next-state logic: capture, column-group mixing and result hand-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_state_d = out_state_q;
`ifdef MIXCOL_INV_EN
    inv_d       = inv_q;
`endif
    mixed_s     = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      mixed_s[127-32*(int'(cnt_q)+k) -: 32] = mix_col(work_q[127-32*(int'(cnt_q)+k) -: 32], inv_sel_s);
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = 2'd0;
          state_d = CALC;
`ifdef MIXCOL_INV_EN
          inv_d   = inv;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        work_d = mixed_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d       = 2'd0;
          out_state_d = mixed_s;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_state = out_state_q;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      CALC:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward AES MixColumns engine for the encryption datapath; the counterpart of the decryption-side InvMixColumns helper.
- Accepts a 128-bit AES state through a valid/ready handshake.
- Processes the state COLS_PER_CYCLE columns per clock over GF(2^8), using the matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03} and {03 01 01 02}.
- Returns the 128-bit result through a second valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in rounds 1-13 of the AES-256 round pipeline.

Parameters:
- COLS_PER_CYCLE, default 1: columns computed per clock. Legal values are 1, 2 and 4. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_state is valid
- in_ready  out  1  engine can accept a state
- in_state  in  128  input state; [127:96] is column 0, [31:0] is column 3; within a column, bits [31:24] hold row 0
- out_valid  out  1  out_state holds a completed result
- out_ready  in  1  downstream accepts the result
- out_state  out  128  mixed state, same byte ordering as in_state
- busy  out  1  high while in the CALC state

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; column counter = 0.
  - Working register and out_state = 0.
  - in_ready=1, out_valid=0, busy=0.
  - If reset asserts mid-operation, any partially mixed state is discarded; no output is produced for it.
- Arithmetic:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - mul2(a) = xtime(a); mul3(a) = xtime(a) ^ a.
  - r0 = 2a0^3a1^a2^a3; r1 = a0^2a1^3a2^a3; r2 = a0^a1^2a2^3a3; r3 = 3a0^a1^a2^2a3.
  - Purely combinational within one cycle; no lookup tables.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready, capture in_state into the working register, clear the counter, go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle, replace columns [cnt .. cnt+COLS_PER_CYCLE-1] of the working register with their mixed values, then cnt += COLS_PER_CYCLE. When the final group is written, copy the fully mixed register to out_state and go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: handshake edge to out_valid high = 4/COLS_PER_CYCLE cycles (4, 2 or 1).
- Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles minimum. The block does not accept new input in the same cycle a result is consumed.
- Backpressure:
  - out_state and out_valid stay stable while out_valid=1 and out_ready=0, for any number of cycles.
  - in_state is ignored outside the accepting cycle; upstream may change it freely.
- Boundary conditions:
  - in_valid high in CALC or DONE: no capture; upstream must hold the data until in_ready is seen.
  - out_ready high in IDLE or CALC: ignored.
  - cnt wraps to 0 on the transition out of CALC and never exceeds 3.
  - X on in_state while in_valid=0 must not propagate into outputs.

Optional Feature:
- Macro name: MIXCOL_INV_EN.
- When defined:
  - Adds input port inv (1 bit), sampled at input capture and held for the whole operation.
  - inv=1 selects the InvMixColumns matrix {0e 0b 0d 09} (rotated per row), built from the xtime chain: mul9 = x^3^1, mulb = x^3^x^1, muld = x^3^x^2^1, mule = x^3^x^2^x.
  - inv=0 behaves as the forward engine.
  - Latency is the same in both modes.
- When undefined: no inv port; forward mode only. All other ports and timing are identical.

Test Plan:
- Reset, then a single state with column 0 = db135345 and columns 1-3 = f20a225c, 01010101, c6c6c6c6 -> out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6. out_valid is high exactly 4 cycles after the input handshake (COLS_PER_CYCLE=1).
- in_state = d4d4d4d5_2d26314c_00000000_ffffffff -> out_state = d5d5d7d6_4d7ebdf8_00000000_ffffffff. Repeat with COLS_PER_CYCLE=2 (latency 2) and COLS_PER_CYCLE=4 (latency 1).
- Hold out_ready=0 for 10 cycles after out_valid -> out_state stable and in_ready=0 throughout; in_valid pulses during this window are not captured.
- Pull rst_n low during the second CALC cycle -> in_ready=1, out_valid=0 and out_state=0 immediately; the next accepted state produces a correct result.
- Back-to-back inputs with out_ready tied high -> accept spacing exactly 6 cycles; results in order.
- With MIXCOL_INV_EN defined: inv=1 on 8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6. A forward pass followed by an inverse pass on 256 random states returns the original state each time.
